// File: rtl/tone_pkg.sv
// Shared types and widths for the tone arbiter: FSM encoding, tone and beat widths.
package tone_pkg;

    localparam int unsigned TONE_W = 32;
    localparam int unsigned BEAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUSIC = 2'd1,
        ST_SFX   = 2'd2,
        ST_GAP   = 2'd3
    } tone_state_e;

    // A programmed length of zero beats still plays for one beat.
    function automatic logic [BEAT_W-1:0] beats_eff(input logic [BEAT_W-1:0] b);
        return (b == '0) ? BEAT_W'(1) : b;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority selector: one-hot grant of the lowest-index set request bit.
module prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/tone_arbiter.sv
// Arbitrates background music against prioritised sound effects and drives the
// frequency input of the tone PWM generator, inserting a silent gap after each effect.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [31:0] GAP_CYC = 32'd1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      beat_tick,
    input  logic [TONE_W-1:0]         music_tone,
    input  logic                      music_en,
    input  logic                      mute,
    input  logic [NUM_REQ-1:0]        sfx_req,
    input  logic [TONE_W*NUM_REQ-1:0] sfx_tone,
    input  logic [BEAT_W*NUM_REQ-1:0] sfx_beats,
    output logic [TONE_W-1:0]         tone_out,
    output logic                      music_hold,
    output logic [NUM_REQ-1:0]        sfx_active,
    output logic [NUM_REQ-1:0]        sfx_done
);

    localparam logic [31:0] GAP_LOAD = (GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1;

    tone_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [NUM_REQ-1:0]  active_q, active_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [31:0]         gap_q, gap_d;
    logic [TONE_W-1:0]   tone_lat_q, tone_lat_d;
    logic [TONE_W-1:0]   tone_out_q, tone_out_d;
    logic                music_hold_q, music_hold_d;
    logic [NUM_REQ-1:0]  sfx_done_q, sfx_done_d;

    logic [NUM_REQ-1:0]  grant_oh;
    logic                grant_vld;
    logic                take_grant;
    logic [NUM_REQ-1:0]  grant_mask;
    logic [TONE_W-1:0]   grant_tone;
    logic [BEAT_W-1:0]   grant_beats;
    logic [BEAT_W-1:0]   active_beats;

    prio_enc #(
        .N (NUM_REQ)
    ) u_prio_enc (
        .req   (pending_q),
        .grant (grant_oh),
        .valid (grant_vld)
    );

    always_comb begin
        grant_tone   = '0;
        grant_beats  = '0;
        active_beats = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_tone  |= sfx_tone[i*TONE_W +: TONE_W];
                grant_beats |= sfx_beats[i*BEAT_W +: BEAT_W];
            end
            if (active_q[i]) begin
                active_beats |= sfx_beats[i*BEAT_W +: BEAT_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        beats_d    = beats_q;
        gap_d      = gap_q;
        tone_lat_d = tone_lat_q;
        sfx_done_d = '0;
        take_grant = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld)     take_grant = 1'b1;
                else if (music_en) state_d    = ST_MUSIC;
            end
            ST_MUSIC: begin
                if (grant_vld)      take_grant = 1'b1;
                else if (!music_en) state_d    = ST_IDLE;
            end
            ST_SFX: begin
                // Preemption beats a restart, which beats completion on the same tick.
                if (grant_vld && (grant_oh < active_q)) begin
                    take_grant = 1'b1;
                end else if ((sfx_req & active_q) != '0) begin
                    beats_d = beats_eff(active_beats);
                end else if (beat_tick) begin
                    if (beats_q <= BEAT_W'(1)) begin
                        state_d    = ST_GAP;
                        sfx_done_d = active_q;
                        gap_d      = GAP_LOAD;
                    end else begin
                        beats_d = beats_q - BEAT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    if (grant_vld)     take_grant = 1'b1;
                    else if (music_en) state_d    = ST_MUSIC;
                    else               state_d    = ST_IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_grant) begin
            state_d    = ST_SFX;
            active_d   = grant_oh;
            beats_d    = beats_eff(grant_beats);
            tone_lat_d = grant_tone;
        end

        if (state_d != ST_SFX) begin
            active_d = '0;
            beats_d  = '0;
        end
        if (state_d != ST_GAP && state_q != ST_GAP) begin
            gap_d = '0;
        end

        // Requests for the playing index, or the index granted this edge, restart instead of queueing.
        grant_mask = active_q | (take_grant ? grant_oh : '0);
        pending_d  = (pending_q & ~(take_grant ? grant_oh : '0)) | (sfx_req & ~grant_mask);

        music_hold_d = (state_d == ST_SFX) || (state_d == ST_GAP);
        if (mute)                     tone_out_d = '0;
        else if (state_d == ST_SFX)   tone_out_d = tone_lat_d;
        else if (state_d == ST_MUSIC) tone_out_d = music_tone;
        else                          tone_out_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            active_q     <= '0;
            beats_q      <= '0;
            gap_q        <= '0;
            tone_lat_q   <= '0;
            tone_out_q   <= '0;
            music_hold_q <= 1'b0;
            sfx_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            beats_q      <= beats_d;
            gap_q        <= gap_d;
            tone_lat_q   <= tone_lat_d;
            tone_out_q   <= tone_out_d;
            music_hold_q <= music_hold_d;
            sfx_done_q   <= sfx_done_d;
        end
    end

    assign tone_out   = tone_out_q;
    assign music_hold = music_hold_q;
    assign sfx_active = active_q;
    assign sfx_done   = sfx_done_q;

endmodule
